// File: rtl/gz_pkg.sv
// Shared GuitarZero lane keycodes, event layout and emit FSM states.
package gz_pkg;

    localparam logic [7:0] KEY_LANE0 = 8'h04;
    localparam logic [7:0] KEY_LANE1 = 8'h16;
    localparam logic [7:0] KEY_LANE2 = 8'h07;
    localparam logic [7:0] KEY_LANE3 = 8'h09;
    localparam logic [7:0] KEY_LANE4 = 8'h0A;
    localparam int NUM_LANES = 5;
    localparam int EVT_HOLD_W = 16;

    typedef struct packed {
        logic                  press;
        logic [2:0]            lane;
        logic [EVT_HOLD_W-1:0] hold;
    } lane_evt_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EMIT_REL,
        ST_EMIT_PRS
    } emit_state_t;

    // Returns {is_lane, lane[2:0]}.
    function automatic logic [3:0] lane_of(input logic [7:0] code);
        logic [3:0] r;
        r = 4'b0000;
        unique case (code)
            KEY_LANE0: r = 4'b1000;
            KEY_LANE1: r = 4'b1001;
            KEY_LANE2: r = 4'b1010;
            KEY_LANE3: r = 4'b1011;
            KEY_LANE4: r = 4'b1100;
            default:   r = 4'b0000;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/evt_fifo.sv
// Synchronous first-word-fall-through FIFO; a push into a full queue
// is accepted only when a pop frees a slot on the same edge.
module evt_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !reset) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/keycode_lane_tracker.sv
// Debounces the PIO keycode, maps lane keys, and queues timestamped
// press/release events alongside a level-held lane vector.
module keycode_lane_tracker
    import gz_pkg::*;
#(
    parameter int STABLE_CYC = 4,
    parameter int HOLD_W     = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        keycode,
    input  logic              tick,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [HOLD_W+3:0] evt_data,
    output logic [4:0]        lane_held,
    output logic              overflow,
    input  logic              ovf_clr
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]        k_q;
    logic [7:0]        cur;
    logic [3:0]        stab;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] rel_hold;
    logic [2:0]        old_lane;
    logic [3:0]        k_map;
    logic [3:0]        cur_map;
    logic              accept;
    emit_state_t       state;
    emit_state_t       state_nx;
    logic              push;
    logic [HOLD_W+3:0] push_data;
    logic              pop;
    logic              q_full;
    logic              q_empty;
    logic [CW-1:0]     q_count;

    assign k_map   = lane_of(k_q);
    assign cur_map = lane_of(cur);
    assign accept  = (stab == 4'(STABLE_CYC)) && (k_q != cur)
                     && (state == ST_IDLE);

    always_comb begin
        lane_held = '0;
        if (cur_map[3]) lane_held[cur_map[2:0]] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            k_q      <= '0;
            stab     <= '0;
            cur      <= '0;
            hold_cnt <= '0;
            rel_hold <= '0;
            old_lane <= '0;
        end else begin
            k_q <= keycode;
            if (keycode != k_q)
                stab <= '0;
            else if (stab != 4'(STABLE_CYC))
                stab <= stab + 1'b1;
            // Accept clears the hold counter even if a tick lands on it.
            if (accept) begin
                cur      <= k_q;
                rel_hold <= hold_cnt;
                hold_cnt <= '0;
                old_lane <= cur_map[2:0];
            end else if (tick && cur_map[3] && hold_cnt != '1) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        push      = 1'b0;
        push_data = '0;
        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (cur_map[3])    state_nx = ST_EMIT_REL;
                    else if (k_map[3]) state_nx = ST_EMIT_PRS;
                end
            end
            ST_EMIT_REL: begin
                push      = 1'b1;
                push_data = {1'b0, old_lane, rel_hold};
                state_nx  = cur_map[3] ? ST_EMIT_PRS : ST_IDLE;
            end
            ST_EMIT_PRS: begin
                push      = 1'b1;
                push_data = {1'b1, cur_map[2:0], {HOLD_W{1'b0}}};
                state_nx  = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign pop       = evt_ready && !q_empty;
    assign evt_valid = (q_count != '0);

    evt_fifo #(
        .WIDTH(HOLD_W + 4),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_data(push_data),
        .pop      (pop),
        .head     (evt_data),
        .full     (q_full),
        .empty    (q_empty),
        .count    (q_count)
    );

    always_ff @(posedge clk) begin
        if (reset)
            overflow <= 1'b0;
        else if (push && q_full && !pop)
            overflow <= 1'b1;
        else if (ovf_clr)
            overflow <= 1'b0;
    end

endmodule

// File: tb/tb_keycode_lane_tracker.sv
// Directed bench for keycode_lane_tracker at default parameters.
module tb_keycode_lane_tracker;
    import gz_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  keycode = 8'h00;
    logic        tick = 1'b0;
    logic        evt_ready = 1'b0;
    logic        ovf_clr = 1'b0;
    logic        evt_valid;
    logic [19:0] evt_data;
    logic [4:0]  lane_held;
    logic        overflow;

    int checks = 0;
    int failures = 0;

    keycode_lane_tracker dut (
        .clk      (clk),
        .reset    (reset),
        .keycode  (keycode),
        .tick     (tick),
        .evt_valid(evt_valid),
        .evt_ready(evt_ready),
        .evt_data (evt_data),
        .lane_held(lane_held),
        .overflow (overflow),
        .ovf_clr  (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [19:0] ev(input logic p, input logic [2:0] l,
                                       input logic [15:0] h);
        lane_evt_t e;
        e.press = p;
        e.lane  = l;
        e.hold  = h;
        return e;
    endfunction

    logic [19:0] exp_q [8];

    initial begin
        step(2);
        chk("rst_valid", 32'(evt_valid), 0);
        chk("rst_data", 32'(evt_data), 0);
        chk("rst_lane", 32'(lane_held), 0);
        chk("rst_ovf", 32'(overflow), 0);
        reset = 1'b0;

        // Press A: lane valid after edge 6, event after edge 7.
        keycode = 8'h04;
        step(5);
        chk("a_lane_e5", 32'(lane_held), 0);
        step(1);
        chk("a_lane_e6", 32'(lane_held), 32'h01);
        chk("a_valid_e6", 32'(evt_valid), 0);
        step(1);
        chk("a_valid_e7", 32'(evt_valid), 1);
        chk("a_data", 32'(evt_data), 32'(ev(1, 0, 0)));
        evt_ready = 1'b1;
        step(1);
        evt_ready = 1'b0;
        chk("a_popped", 32'(evt_valid), 0);

        // Ten ticks of hold, then release.
        for (int i = 0; i < 10; i++) begin
            tick = 1'b1;
            step(1);
            tick = 1'b0;
            step(1);
        end
        keycode = 8'h00;
        step(6);
        chk("rel_lane", 32'(lane_held), 0);
        step(1);
        chk("rel_valid", 32'(evt_valid), 1);
        chk("rel_data", 32'(evt_data), 32'(ev(0, 0, 10)));
        evt_ready = 1'b1;
        step(1);
        evt_ready = 1'b0;

        // A, three ticks, then straight to S.
        keycode = 8'h04;
        step(7);
        chk("a2_data", 32'(evt_data), 32'(ev(1, 0, 0)));
        evt_ready = 1'b1;
        step(1);
        evt_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick = 1'b1;
            step(1);
            tick = 1'b0;
            step(1);
        end
        keycode = 8'h16;
        step(6);
        chk("as_lane", 32'(lane_held), 32'h02);
        step(1);
        chk("as_rel", 32'(evt_data), 32'(ev(0, 0, 3)));
        step(1);
        chk("as_rel_hold", 32'(evt_data), 32'(ev(0, 0, 3)));
        evt_ready = 1'b1;
        step(1);
        chk("as_prs", 32'(evt_data), 32'(ev(1, 1, 0)));
        chk("as_prs_v", 32'(evt_valid), 1);
        step(1);
        evt_ready = 1'b0;
        chk("as_empty", 32'(evt_valid), 0);

        keycode = 8'h00;
        step(7);
        chk("s_rel", 32'(evt_data), 32'(ev(0, 1, 0)));
        evt_ready = 1'b1;
        step(1);
        evt_ready = 1'b0;

        // Short glitch on D.
        keycode = 8'h07;
        step(3);
        keycode = 8'h00;
        step(10);
        chk("glitch_lane", 32'(lane_held), 0);
        chk("glitch_valid", 32'(evt_valid), 0);

        // Nine events into an eight-deep queue.
        exp_q[0] = ev(1, 0, 0);
        exp_q[1] = ev(0, 0, 0);
        exp_q[2] = ev(1, 1, 0);
        exp_q[3] = ev(0, 1, 0);
        exp_q[4] = ev(1, 2, 0);
        exp_q[5] = ev(0, 2, 0);
        exp_q[6] = ev(1, 3, 0);
        exp_q[7] = ev(0, 3, 0);
        keycode = 8'h04; step(8);
        keycode = 8'h00; step(8);
        keycode = 8'h16; step(8);
        keycode = 8'h00; step(8);
        keycode = 8'h07; step(8);
        keycode = 8'h00; step(8);
        keycode = 8'h09; step(8);
        keycode = 8'h00; step(8);
        chk("ovf_pre", 32'(overflow), 0);
        keycode = 8'h0A; step(8);
        chk("ovf_set", 32'(overflow), 1);
        chk("ovf_lane", 32'(lane_held), 32'h10);
        ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        chk("ovf_clr", 32'(overflow), 0);
        evt_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain_v%0d", i), 32'(evt_valid), 1);
            chk($sformatf("drain_d%0d", i), 32'(evt_data), 32'(exp_q[i]));
            step(1);
        end
        evt_ready = 1'b0;
        chk("drain_empty", 32'(evt_valid), 0);

        // Reset right after accepting F.
        keycode = 8'h09;
        step(6);
        chk("f_lane", 32'(lane_held), 32'h08);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("mid_rst_valid", 32'(evt_valid), 0);
        chk("mid_rst_data", 32'(evt_data), 0);
        chk("mid_rst_lane", 32'(lane_held), 0);
        chk("mid_rst_ovf", 32'(overflow), 0);
        step(1);
        chk("mid_rst_valid2", 32'(evt_valid), 0);
        step(5);
        chk("f2_lane", 32'(lane_held), 32'h08);
        step(1);
        chk("f2_valid", 32'(evt_valid), 1);
        chk("f2_data", 32'(evt_data), 32'(ev(1, 3, 0)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
